// File: rtl/cam_cfg_pkg.sv
// Shared constants for the OV camera SCCB init tables: sensor model codes,
// table lengths, DVP geometry register addresses and the fixed OV7670 VGA/RGB565 set.
package cam_cfg_pkg;

  localparam int CAM_OV7670 = 7670;
  localparam int CAM_OV5640 = 5640;

  localparam int OV7670_CFG_SIZE = 172;
  localparam int OV5640_CFG_SIZE = 259;

  localparam logic [15:0] REG_DVPHO_H = 16'h3808;
  localparam logic [15:0] REG_DVPHO_L = 16'h3809;
  localparam logic [15:0] REG_DVPVO_H = 16'h380A;
  localparam logic [15:0] REG_DVPVO_L = 16'h380B;

  // {regaddr[7:0], wrdata[7:0]}; entry 0 is the COM7 soft reset
  localparam logic [15:0] OV7670_CFG [OV7670_CFG_SIZE] = '{
    16'h1280, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00, 16'h0400, 16'h40D0, 16'h3A04, 16'h3DC8, 16'h1438,
    16'h4FB3, 16'h50B3, 16'h5100, 16'h523D, 16'h53A7, 16'h54E4, 16'h589E, 16'h1714, 16'h1804, 16'h3280,
    16'h1903, 16'h1A7B, 16'h030A, 16'h0F41, 16'h1E00, 16'h330B, 16'h3C78, 16'h6900, 16'h7400, 16'hB084,
    16'hB10C, 16'hB20E, 16'hB380, 16'h703A, 16'h7135, 16'h7211, 16'h73F0, 16'hA202, 16'h7A20, 16'h7B10,
    16'h7C1E, 16'h7D35, 16'h7E5A, 16'h7F69, 16'h8076, 16'h8180, 16'h8288, 16'h838F, 16'h8496, 16'h85A3,
    16'h86AF, 16'h87C4, 16'h88D7, 16'h89E8, 16'h13E0, 16'h0000, 16'h1000, 16'h0D40, 16'hA505, 16'hAB07,
    16'h2495, 16'h2533, 16'h26E3, 16'h9F78, 16'hA068, 16'hA103, 16'hA6D8, 16'hA7D8, 16'hA8F0, 16'hA990,
    16'hAA94, 16'h13E5, 16'h0E61, 16'h1602, 16'h2102, 16'h2291, 16'h2907, 16'h350B, 16'h371D, 16'h3871,
    16'h392A, 16'h4D40, 16'h4E20, 16'h6B4A, 16'h8D4F, 16'h8E00, 16'h8F00, 16'h9000, 16'h9100, 16'h9600,
    16'h9A00, 16'hB80A, 16'h4314, 16'h44F0, 16'h4534, 16'h4658, 16'h4728, 16'h483A, 16'h5988, 16'h5A88,
    16'h5B44, 16'h5C67, 16'h5D49, 16'h5E0E, 16'h6C0A, 16'h6D55, 16'h6E11, 16'h6F9F, 16'h6A40, 16'h0140,
    16'h0260, 16'h13E7, 16'h4108, 16'h3F00, 16'h7505, 16'h76E1, 16'h4C00, 16'h7701, 16'h4B09, 16'hC960,
    16'h5640, 16'h3411, 16'h3B12, 16'hA488, 16'h9730, 16'h9820, 16'h9930, 16'h9A84, 16'h9B29, 16'h9C03,
    16'h9D4C, 16'h9E3F, 16'h7804, 16'h7901, 16'hC8F0, 16'h790F, 16'hC800, 16'h7910, 16'hC87E, 16'h790A,
    16'hC880, 16'h790B, 16'hC801, 16'h790C, 16'hC80F, 16'h790D, 16'hC820, 16'h7909, 16'hC880, 16'h7902,
    16'hC8C0, 16'h7903, 16'hC840, 16'h7905, 16'hC830, 16'h7926, 16'h2A00, 16'h2B00, 16'h9200, 16'h9300,
    16'h3B0A, 16'h1500, 16'h4238, 16'h7A20, 16'h5500, 16'h1E07, 16'h3E00, 16'h7019, 16'h7135, 16'h7211,
    16'h73F1, 16'hA202
  };

endpackage

// File: rtl/cam_sensor_config_rom_if.sv
// Index/entry bus between the SCCB sequencer (master) and the config ROM (slave).
interface cam_sensor_config_rom_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       rom_addr;
  logic [DATA_W-1:0] rom_data_n;
  logic [DATA_W-1:0] rom_data_q;
  logic [15:0]       config_size;

  modport master (output rom_addr, input rom_data_n, rom_data_q, config_size);
  modport slave  (input rom_addr, output rom_data_n, rom_data_q, config_size);
endinterface

// File: rtl/cam_cfg_table_lookup.sv
// Zero-latency {regaddr, wrdata} lookup for the selected sensor; indices past
// the end of the table read as zero.
module cam_cfg_table_lookup
  import cam_cfg_pkg::*;
#(
  parameter int          CAMERA_MODEL = CAM_OV7670,
  parameter int          DATA_W       = 16,
  parameter logic [15:0] DVPHO        = 16'd640,
  parameter logic [15:0] DVPVO        = 16'd480
) (
  input  logic [15:0]       rom_addr,
  output logic [DATA_W-1:0] entry
);

  if (CAMERA_MODEL == CAM_OV5640) begin : g_ov5640
    // Output geometry (0x3808..0x380B) is the only parameter-dependent part of the set
    localparam logic [23:0] TABLE [OV5640_CFG_SIZE] = '{
      24'h310311, 24'h300882, 24'h300842, 24'h310303, 24'h301700, 24'h301800, 24'h303408, 24'h303521,
      24'h303669, 24'h303713, 24'h310801, 24'h363036, 24'h36310E, 24'h3632E2, 24'h363312, 24'h3621E0,
      24'h3704A0, 24'h37035A, 24'h371578, 24'h371701, 24'h370B60, 24'h37051A, 24'h390502, 24'h390610,
      24'h39010A, 24'h373112, 24'h360008, 24'h360133, 24'h302D60, 24'h362052, 24'h371B20, 24'h471C50,
      24'h3A1343, 24'h3A1800, 24'h3A19F8, 24'h363513, 24'h363603, 24'h363440, 24'h362201, 24'h3C0134,
      24'h3C0428, 24'h3C0598, 24'h3C0600, 24'h3C0708, 24'h3C0800, 24'h3C091C, 24'h3C0A9C, 24'h3C0B40,
      24'h382041, 24'h382107, 24'h381431, 24'h381531, 24'h380000, 24'h380100, 24'h380200, 24'h380304,
      24'h38040A, 24'h38053F, 24'h380607, 24'h38079B,
      {REG_DVPHO_H, DVPHO[15:8]}, {REG_DVPHO_L, DVPHO[7:0]},
      {REG_DVPVO_H, DVPVO[15:8]}, {REG_DVPVO_L, DVPVO[7:0]},
      24'h380C07, 24'h380D68, 24'h380E03, 24'h380FD8, 24'h381000, 24'h381110, 24'h381200, 24'h381306,
      24'h361800, 24'h361229, 24'h370852, 24'h370903, 24'h370C03, 24'h3A0202, 24'h3A03E4, 24'h3A0800,
      24'h3A09B9, 24'h3A0A00, 24'h3A0B8A, 24'h3A0E03, 24'h3A0D04, 24'h3A1402, 24'h3A15E4, 24'h400102,
      24'h400402, 24'h300002, 24'h30021C, 24'h3006C3, 24'h300E58, 24'h302E00, 24'h430061, 24'h501F01,
      24'h471303, 24'h440704, 24'h460B35, 24'h460C22, 24'h482422, 24'h500106, 24'h500300, 24'h3C0004,
      24'h5180FF, 24'h5181F2, 24'h518200, 24'h518314, 24'h518425, 24'h518524, 24'h518609, 24'h518709,
      24'h518809, 24'h518975, 24'h518A54, 24'h518BE0, 24'h518CB2, 24'h518D42, 24'h518E3D, 24'h518F56,
      24'h519046, 24'h5191F8, 24'h519204, 24'h519370, 24'h5194F0, 24'h5195F0, 24'h519603, 24'h519701,
      24'h519804, 24'h519912, 24'h519A04, 24'h519B00, 24'h519C06, 24'h519D82, 24'h519E38, 24'h53811E,
      24'h53825B, 24'h538308, 24'h53840A, 24'h53857E, 24'h538688, 24'h53877C, 24'h53886C, 24'h538910,
      24'h538A01, 24'h538B98, 24'h530008, 24'h530130, 24'h530210, 24'h530300, 24'h530408, 24'h530530,
      24'h530608, 24'h530716, 24'h530908, 24'h530A30, 24'h530B04, 24'h530C06, 24'h548001, 24'h548108,
      24'h548214, 24'h548328, 24'h548451, 24'h548565, 24'h548671, 24'h54877D, 24'h548887, 24'h548991,
      24'h548A9A, 24'h548BAA, 24'h548CB8, 24'h548DCD, 24'h548EDD, 24'h548FEA, 24'h54901D, 24'h558006,
      24'h558340, 24'h558410, 24'h558910, 24'h558A00, 24'h558BF8, 24'h502500, 24'h3A0F30, 24'h3A1028,
      24'h3A1B30, 24'h3A1E26, 24'h3A1160, 24'h3A1F14, 24'h580023, 24'h580114, 24'h58020F, 24'h58030F,
      24'h580412, 24'h580526, 24'h58060C, 24'h580708, 24'h580805, 24'h580905, 24'h580A08, 24'h580B0D,
      24'h580C08, 24'h580D03, 24'h580E00, 24'h580F00, 24'h581003, 24'h581109, 24'h581207, 24'h581303,
      24'h581400, 24'h581501, 24'h581603, 24'h581708, 24'h58180D, 24'h581908, 24'h581A05, 24'h581B06,
      24'h581C08, 24'h581D0E, 24'h581E29, 24'h581F17, 24'h582011, 24'h582111, 24'h582215, 24'h582328,
      24'h582446, 24'h582526, 24'h582608, 24'h582726, 24'h582864, 24'h582926, 24'h582A24, 24'h582B22,
      24'h582C24, 24'h582D24, 24'h582E06, 24'h582F22, 24'h583040, 24'h583142, 24'h583224, 24'h583326,
      24'h583424, 24'h583522, 24'h583622, 24'h583726, 24'h583844, 24'h583924, 24'h583A26, 24'h583B28,
      24'h583C42, 24'h583DCE, 24'h350300, 24'h3B0708, 24'h474000, 24'h473008, 24'h3A0078, 24'h530825,
      24'h350A00, 24'h350B3F, 24'h300802
    };

    always_comb begin
      entry = '0;
      if (rom_addr < 16'(OV5640_CFG_SIZE)) entry = DATA_W'(TABLE[rom_addr[8:0]]);
    end
  end else begin : g_ov7670
    // DVP geometry only applies to the OV5640 table
    logic unused_dvp;
    assign unused_dvp = ^{DVPHO, DVPVO};

    always_comb begin
      entry = '0;
      if (rom_addr < 16'(OV7670_CFG_SIZE)) entry = DATA_W'(OV7670_CFG[rom_addr[7:0]]);
    end
  end

endmodule

// File: rtl/cam_sensor_config_rom.sv
// OV7670/OV5640 SCCB init ROM: combinational entry plus a one-cycle registered copy
// (async-cleared); config_size is a constant per sensor.
module cam_sensor_config_rom
  import cam_cfg_pkg::*;
#(
  parameter int          CAMERA_MODEL  = CAM_OV7670,
  parameter int          REGADDR_WIDTH = 8,
  parameter logic [15:0] DVPHO         = 16'd640,
  parameter logic [15:0] DVPVO         = 16'd480
) (
  input  logic                    clk,
  input  logic                    reset,
  cam_sensor_config_rom_if.slave  bus
);

  localparam int DATA_W  = REGADDR_WIDTH + 8;
  localparam bit IS_5640 = (CAMERA_MODEL == CAM_OV5640);

  if (IS_5640 ? (REGADDR_WIDTH != 16) : (REGADDR_WIDTH != 8)) begin : g_cfg_err
    $error("cam_sensor_config_rom: REGADDR_WIDTH %0d does not match CAMERA_MODEL %0d",
           REGADDR_WIDTH, CAMERA_MODEL);
  end

  logic [DATA_W-1:0] entry;

  cam_cfg_table_lookup #(
    .CAMERA_MODEL (CAMERA_MODEL),
    .DATA_W       (DATA_W),
    .DVPHO        (DVPHO),
    .DVPVO        (DVPVO)
  ) u_lookup (
    .rom_addr (bus.rom_addr),
    .entry    (entry)
  );

  assign bus.rom_data_n  = entry;
  assign bus.config_size = IS_5640 ? 16'(OV5640_CFG_SIZE) : 16'(OV7670_CFG_SIZE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.rom_data_q <= '0;
    else       bus.rom_data_q <= entry;
  end

endmodule

// File: tb/tb_cam_sensor_config_rom.sv
// Bench for cam_sensor_config_rom: four configurations, scoreboard on the registered path.
module tb_cam_sensor_config_rom;

  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  cam_sensor_config_rom_if #(.DATA_W(16)) b7670 ();
  cam_sensor_config_rom_if #(.DATA_W(24)) b5640a ();
  cam_sensor_config_rom_if #(.DATA_W(24)) b5640b ();
  cam_sensor_config_rom_if #(.DATA_W(16)) b1234 ();

  cam_sensor_config_rom u7670 (.clk(clk), .reset(reset), .bus(b7670.slave));

  cam_sensor_config_rom #(
    .CAMERA_MODEL(5640), .REGADDR_WIDTH(16), .DVPHO(16'd640), .DVPVO(16'd480)
  ) u5640a (.clk(clk), .reset(reset), .bus(b5640a.slave));

  cam_sensor_config_rom #(
    .CAMERA_MODEL(5640), .REGADDR_WIDTH(16), .DVPHO(16'd1280), .DVPVO(16'd720)
  ) u5640b (.clk(clk), .reset(reset), .bus(b5640b.slave));

  cam_sensor_config_rom #(
    .CAMERA_MODEL(1234), .REGADDR_WIDTH(8)
  ) u1234 (.clk(clk), .reset(reset), .bus(b1234.slave));

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Known entries fixed for each sensor; stimulus only uses these or out-of-range indices
  function automatic logic [31:0] exp7(input logic [15:0] a);
    return (a == 16'd0) ? 32'h1280 : 32'h0;
  endfunction

  function automatic logic [31:0] exp5(input logic [15:0] a);
    case (a)
      16'd0:   return 32'h310311;
      16'd1:   return 32'h300882;
      16'd258: return 32'h300802;
      default: return 32'h0;
    endcase
  endfunction

  logic [15:0] a7_tab [10] = '{16'd0, 16'd172, 16'd0, 16'hFFFF, 16'd0, 16'd200, 16'd0, 16'd0, 16'd173, 16'd0};
  logic [15:0] a5_tab [10] = '{16'd0, 16'd1, 16'd258, 16'd259, 16'd1, 16'd0, 16'hFFFF, 16'd258, 16'd1, 16'd0};

  logic [31:0] sb7 [$];
  logic [31:0] sb5 [$];

  logic [15:0] dvp_reg [4] = '{16'h3808, 16'h3809, 16'h380A, 16'h380B};
  logic [7:0]  exp_a   [4] = '{8'h02, 8'h80, 8'h01, 8'hE0};
  logic [7:0]  exp_b   [4] = '{8'h05, 8'h00, 8'h02, 8'hD0};
  int          cnt_a   [4] = '{default: 0};
  int          cnt_b   [4] = '{default: 0};
  logic [7:0]  dat_a   [4] = '{default: 8'h0};
  logic [7:0]  dat_b   [4] = '{default: 8'h0};
  int          ff_hits = 0;
  int          oob_nz  = 0;
  int          diff    = 0;

  initial begin
    reset = 1'b0;
    b7670.rom_addr  = 16'd0;
    b5640a.rom_addr = 16'd0;
    b5640b.rom_addr = 16'd0;
    b1234.rom_addr  = 16'd0;

    // Asynchronous clear before the first clock edge
    #2 reset = 1'b1;
    #1;
    check_val("rst_q7670",  32'(b7670.rom_data_q),  32'h0);
    check_val("rst_q5640a", 32'(b5640a.rom_data_q), 32'h0);
    check_val("rst_q5640b", 32'(b5640b.rom_data_q), 32'h0);
    check_val("rst_q1234",  32'(b1234.rom_data_q),  32'h0);
    check_val("size7670",   32'(b7670.config_size),  32'd172);
    check_val("size5640a",  32'(b5640a.config_size), 32'd259);
    check_val("size5640b",  32'(b5640b.config_size), 32'd259);
    check_val("size1234",   32'(b1234.config_size),  32'd172);
    check_val("rst_n7670",  32'(b7670.rom_data_n),   32'h1280);
    check_val("rst_n5640a", 32'(b5640a.rom_data_n),  32'h310311);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Registered path trails the combinational one by exactly one edge
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b7670.rom_addr  = a7_tab[i];
      b5640a.rom_addr = a5_tab[i];
      #1;
      check_val($sformatf("n7670[%0d]", i), 32'(b7670.rom_data_n),  exp7(a7_tab[i]));
      check_val($sformatf("n5640[%0d]", i), 32'(b5640a.rom_data_n), exp5(a5_tab[i]));
      sb7.push_back(exp7(a7_tab[i]));
      sb5.push_back(exp5(a5_tab[i]));
      @(posedge clk);
      #1;
      check_val($sformatf("q7670[%0d]", i), 32'(b7670.rom_data_q),  sb7.pop_front());
      check_val($sformatf("q5640[%0d]", i), 32'(b5640a.rom_data_q), sb5.pop_front());
    end

    // Reset pulse between edges clears only the registered copy
    @(negedge clk);
    b7670.rom_addr  = 16'd0;
    b5640a.rom_addr = 16'd1;
    @(posedge clk);
    #1;
    check_val("pre_q7670", 32'(b7670.rom_data_q),  32'h1280);
    check_val("pre_q5640", 32'(b5640a.rom_data_q), 32'h300882);
    #2 reset = 1'b1;
    #1;
    check_val("arst_q7670", 32'(b7670.rom_data_q),  32'h0);
    check_val("arst_q5640", 32'(b5640a.rom_data_q), 32'h0);
    check_val("arst_n7670", 32'(b7670.rom_data_n),  32'h1280);
    check_val("arst_n5640", 32'(b5640a.rom_data_n), 32'h300882);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_q7670", 32'(b7670.rom_data_q),  32'h1280);

    // OV5640 scan: geometry registers each appear once with parameter-derived data
    for (int i = 0; i < 259; i++) begin
      @(negedge clk);
      b5640a.rom_addr = 16'(i);
      b5640b.rom_addr = 16'(i);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (b5640a.rom_data_n[23:8] == dvp_reg[k]) begin
          cnt_a[k]++;
          dat_a[k] = b5640a.rom_data_n[7:0];
        end
        if (b5640b.rom_data_n[23:8] == dvp_reg[k]) begin
          cnt_b[k]++;
          dat_b[k] = b5640b.rom_data_n[7:0];
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("cnt_a_%h", dvp_reg[k]), 32'(cnt_a[k]), 32'd1);
      check_val($sformatf("dat_a_%h", dvp_reg[k]), 32'(dat_a[k]), 32'(exp_a[k]));
      check_val($sformatf("cnt_b_%h", dvp_reg[k]), 32'(cnt_b[k]), 32'd1);
      check_val($sformatf("dat_b_%h", dvp_reg[k]), 32'(dat_b[k]), 32'(exp_b[k]));
    end
    @(negedge clk);
    b5640a.rom_addr = 16'd259;
    b5640b.rom_addr = 16'hFFFF;
    #1;
    check_val("oob259_5640a",  32'(b5640a.rom_data_n), 32'h0);
    check_val("oobFFFF_5640b", 32'(b5640b.rom_data_n), 32'h0);

    // OV7670 scan, and the unknown model must behave exactly like OV7670
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      b7670.rom_addr = 16'(i);
      b1234.rom_addr = 16'(i);
      #1;
      if (i < 172 && b7670.rom_data_n[15:8] == 8'hFF) ff_hits++;
      if (i >= 172 && b7670.rom_data_n !== 16'h0) oob_nz++;
      if (b1234.rom_data_n !== b7670.rom_data_n) diff++;
    end
    check_val("ff_regaddr_7670", 32'(ff_hits), 32'd0);
    check_val("oob_nonzero_7670", 32'(oob_nz), 32'd0);
    check_val("model1234_diff", 32'(diff), 32'd0);
    @(negedge clk);
    b7670.rom_addr = 16'hFFFF;
    b1234.rom_addr = 16'd0;
    #1;
    check_val("oobFFFF_7670", 32'(b7670.rom_data_n), 32'h0);
    check_val("idx0_1234",    32'(b1234.rom_data_n), 32'h1280);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
